// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core request/grant/response to APB initiator bridge
// One transfer at a time, absorbs wait states, reports PSLVERR and aborts on timeout.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rvalid_q, rvalid_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          paddr_d   = addr_i;
          pwdata_d  = wdata_i;
          pwrite_d  = we_i;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rvalid_d  = 1'b1;
          rdata_d   = pwrite_q ? 32'h0 : PRDATA;
          err_d     = PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          // cnt_q counts earlier low cycles, so this one is the threshold-th
          if (32'(cnt_q) == TIMEOUT_CYCLES - 1) begin
            rvalid_d  = 1'b1;
            rdata_d   = 32'h0;
            err_d     = 1'b1;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o    = (state_q == IDLE) && req_i;
  assign busy_o   = (state_q != IDLE);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_apb_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_i;
  logic [11:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge HCLK);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // reset state
    next_cycle(); settle();
    check_eq("rst_psel", 32'(PSEL), 0);
    check_eq("rst_penable", 32'(PENABLE), 0);
    check_eq("rst_pwrite", 32'(PWRITE), 0);
    check_eq("rst_paddr", 32'(PADDR), 0);
    check_eq("rst_pwdata", PWDATA, 0);
    check_eq("rst_rvalid", 32'(rvalid_o), 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_err", 32'(err_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    req_i = 1'b1; settle();
    check_eq("rst_gnt_follows_req", 32'(gnt_o), 1);
    req_i = 1'b0;
    next_cycle(); HRESETn = 1'b1;

    // zero-wait write
    next_cycle(); req_i = 1'b1; addr_i = 12'h010; we_i = 1'b1; wdata_i = 32'hA5A5_0001; PREADY = 1'b1; settle();
    check_eq("w0_c0_gnt", 32'(gnt_o), 1);
    next_cycle(); req_i = 1'b0; addr_i = 12'hFFF; wdata_i = 32'h0; settle();
    check_eq("w0_c1_gnt", 32'(gnt_o), 0);
    check_eq("w0_c1_psel_pen", {30'h0, PSEL, PENABLE}, 32'h2);
    check_eq("w0_c1_paddr", 32'(PADDR), 32'h010);
    check_eq("w0_c1_pwdata", PWDATA, 32'hA5A5_0001);
    check_eq("w0_c1_pwrite", 32'(PWRITE), 1);
    check_eq("w0_c1_busy", 32'(busy_o), 1);
    next_cycle(); settle();
    check_eq("w0_c2_psel_pen", {30'h0, PSEL, PENABLE}, 32'h3);
    check_eq("w0_c2_rvalid", 32'(rvalid_o), 0);
    next_cycle(); settle();
    check_eq("w0_c3_rvalid", 32'(rvalid_o), 1);
    check_eq("w0_c3_err", 32'(err_o), 0);
    check_eq("w0_c3_rdata", rdata_o, 0);
    check_eq("w0_c3_psel_pen", {30'h0, PSEL, PENABLE}, 32'h0);
    check_eq("w0_c3_busy", 32'(busy_o), 0);
    check_eq("w0_c3_paddr_held", 32'(PADDR), 32'h010);
    next_cycle(); settle();
    check_eq("w0_c4_rvalid", 32'(rvalid_o), 0);

    // read with 3 wait states
    next_cycle(); req_i = 1'b1; addr_i = 12'h404; we_i = 1'b0; PREADY = 1'b0; settle();
    check_eq("r3_c0_gnt", 32'(gnt_o), 1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); req_i = 1'b0; addr_i = 12'h000;
      if (c == 5) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
      settle();
      check_eq($sformatf("r3_c%0d_paddr", c), 32'(PADDR), 32'h404);
      check_eq($sformatf("r3_c%0d_psel", c), 32'(PSEL), 1);
      check_eq($sformatf("r3_c%0d_penable", c), 32'(PENABLE), (c == 1) ? 0 : 1);
      check_eq($sformatf("r3_c%0d_rvalid", c), 32'(rvalid_o), 0);
    end
    next_cycle(); PRDATA = 32'hDEAD_BEEF; settle();
    check_eq("r3_c6_rvalid", 32'(rvalid_o), 1);
    check_eq("r3_c6_rdata", rdata_o, 32'h1234_5678);
    check_eq("r3_c6_err", 32'(err_o), 0);

    // slave error on write, then a clean read
    next_cycle(); req_i = 1'b1; addr_i = 12'h020; we_i = 1'b1; wdata_i = 32'h5555_AAAA; PREADY = 1'b1; PSLVERR = 1'b1; settle();
    next_cycle(); req_i = 1'b0; settle();
    next_cycle(); settle();
    next_cycle(); PSLVERR = 1'b0; settle();
    check_eq("se_rvalid", 32'(rvalid_o), 1);
    check_eq("se_err", 32'(err_o), 1);
    check_eq("se_rdata", rdata_o, 0);
    next_cycle(); req_i = 1'b1; addr_i = 12'h024; we_i = 1'b0; PRDATA = 32'hCAFE_0042; settle();
    check_eq("se_err_held", 32'(err_o), 1);
    check_eq("se_rvalid_one_cycle", 32'(rvalid_o), 0);
    next_cycle(); req_i = 1'b0; settle();
    next_cycle(); settle();
    next_cycle(); settle();
    check_eq("se2_rvalid", 32'(rvalid_o), 1);
    check_eq("se2_err", 32'(err_o), 0);
    check_eq("se2_rdata", rdata_o, 32'hCAFE_0042);

    // timeout with PREADY held low (threshold 4)
    next_cycle(); req_i = 1'b1; addr_i = 12'h100; we_i = 1'b0; PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF; settle();
    next_cycle(); req_i = 1'b0; settle();
    for (int c = 2; c <= 5; c++) begin
      next_cycle(); settle();
      check_eq($sformatf("to_c%0d_psel_pen", c), {30'h0, PSEL, PENABLE}, 32'h3);
    end
    next_cycle(); settle();
    check_eq("to_c6_psel_pen", {30'h0, PSEL, PENABLE}, 32'h0);
    check_eq("to_c6_rvalid", 32'(rvalid_o), 1);
    check_eq("to_c6_err", 32'(err_o), 1);
    check_eq("to_c6_rdata", rdata_o, 0);
    check_eq("to_c6_busy", 32'(busy_o), 0);

    // PREADY rises exactly on the 4th ACCESS cycle: normal completion
    next_cycle(); req_i = 1'b1; addr_i = 12'h104; settle();
    next_cycle(); req_i = 1'b0; settle();
    next_cycle(); settle();
    next_cycle(); settle();
    next_cycle(); settle();
    next_cycle(); PREADY = 1'b1; PRDATA = 32'h0BAD_F00D; settle();
    check_eq("tr_c5_penable", 32'(PENABLE), 1);
    next_cycle(); settle();
    check_eq("tr_c6_rvalid", 32'(rvalid_o), 1);
    check_eq("tr_c6_err", 32'(err_o), 0);
    check_eq("tr_c6_rdata", rdata_o, 32'h0BAD_F00D);

    // back-to-back reads with req held high
    next_cycle(); req_i = 1'b1; addr_i = 12'h200; we_i = 1'b0; PREADY = 1'b1; PRDATA = 32'h1111_1111; settle();
    check_eq("bb_c0_gnt", 32'(gnt_o), 1);
    next_cycle(); addr_i = 12'h204; settle();
    check_eq("bb_c1_gnt", 32'(gnt_o), 0);
    next_cycle(); settle();
    check_eq("bb_c2_rvalid", 32'(rvalid_o), 0);
    next_cycle(); PRDATA = 32'h2222_2222; settle();
    check_eq("bb_c3_rvalid", 32'(rvalid_o), 1);
    check_eq("bb_c3_gnt", 32'(gnt_o), 1);
    check_eq("bb_c3_rdata", rdata_o, 32'h1111_1111);
    next_cycle(); req_i = 1'b0; settle();
    check_eq("bb_c4_paddr", 32'(PADDR), 32'h204);
    check_eq("bb_c4_rvalid", 32'(rvalid_o), 0);
    next_cycle(); settle();
    next_cycle(); settle();
    check_eq("bb_c6_rvalid", 32'(rvalid_o), 1);
    check_eq("bb_c6_rdata", rdata_o, 32'h2222_2222);

    // reset while in ACCESS with PREADY low
    next_cycle(); req_i = 1'b1; addr_i = 12'h300; we_i = 1'b1; wdata_i = 32'h7777_0000; PREADY = 1'b0; settle();
    next_cycle(); req_i = 1'b0; settle();
    next_cycle(); settle();
    check_eq("ra_c2_penable", 32'(PENABLE), 1);
    HRESETn = 1'b0; settle();
    check_eq("ra_psel_pen", {30'h0, PSEL, PENABLE}, 32'h0);
    check_eq("ra_busy", 32'(busy_o), 0);
    check_eq("ra_paddr", 32'(PADDR), 0);
    check_eq("ra_rdata", rdata_o, 0);
    next_cycle(); PREADY = 1'b1; settle();
    check_eq("ra_no_rvalid", 32'(rvalid_o), 0);
    HRESETn = 1'b1;
    next_cycle(); settle();
    check_eq("ra_post_rvalid", 32'(rvalid_o), 0);
    next_cycle(); req_i = 1'b1; addr_i = 12'h0AC; we_i = 1'b0; PRDATA = 32'h600D_0001; settle();
    check_eq("ra_new_gnt", 32'(gnt_o), 1);
    next_cycle(); req_i = 1'b0; settle();
    next_cycle(); settle();
    next_cycle(); settle();
    check_eq("ra_new_rvalid", 32'(rvalid_o), 1);
    check_eq("ra_new_rdata", rdata_o, 32'h600D_0001);
    check_eq("ra_new_err", 32'(err_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
